// File: rtl/vga_pkg.sv
// Shared VGA constants and the box-draw controller state encoding.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/box_scanner.sv
// Column/row sweep of a square box: produces the next pixel position, its
// on-screen flag, and whether the pixel currently on the VGA bus is the last one.
module box_scanner #(
    parameter int X_W    = vga_pkg::X_W,
    parameter int Y_W    = vga_pkg::Y_W,
    parameter int SIZE_W = 5
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              step,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [SIZE_W-1:0] size,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              in_bounds,
    output logic              last
);

    localparam logic [X_W:0] X_LIMIT = (X_W+1)'(vga_pkg::SCREEN_W);
    localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(vga_pkg::SCREEN_H);

    // col/row index the pixel currently shown; next_* is the one loaded next.
    logic [SIZE_W-1:0] col, row, next_col, next_row, size_m1;
    logic [X_W:0]      x_sum;
    logic [Y_W:0]      y_sum;
    logic              row_end;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_col = '0;
        next_row = '0;
        size_m1  = size - SIZE_W'(1);
        row_end  = (col == size_m1);
        last     = row_end && (row == size_m1);
        if (!start) begin
            if (row_end) begin
                next_row = row + SIZE_W'(1);
            end else begin
                next_col = col + SIZE_W'(1);
                next_row = row;
            end
        end
        x_sum     = {1'b0, x0} + (X_W+1)'(next_col);
        y_sum     = {1'b0, y0} + (Y_W+1)'(next_row);
        x         = x_sum[X_W-1:0];
        y         = y_sum[Y_W-1:0];
        in_bounds = (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (start || step) begin
            col <= next_col;
            row <= next_row;
        end
    end

endmodule

// File: rtl/box_draw_arbiter.sv
// Round-robin owner of the draw_box datapath and VGA adapter: grants one box
// request at a time and sweeps it onto the VGA port one pixel per cycle.
module box_draw_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int X_W     = vga_pkg::X_W,
    parameter  int Y_W     = vga_pkg::Y_W,
    parameter  int SIZE_W  = 5,
    parameter  int COL_W   = vga_pkg::COL_W,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*X_W-1:0]    req_x,
    input  logic [NUM_REQ*Y_W-1:0]    req_y,
    input  logic [NUM_REQ*SIZE_W-1:0] req_size,
    input  logic [NUM_REQ*COL_W-1:0]  req_colour,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [COL_W-1:0]          vga_colour,
    output logic                      vga_plot,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id
);

    import vga_pkg::state_t, vga_pkg::IDLE, vga_pkg::DRAW, vga_pkg::DONE;

    state_t              state;
    logic [ID_W-1:0]     last_id, cur_id, gnt_id;
    logic [NUM_REQ-1:0]  gnt_onehot;
    logic                gnt_any, idle, accept;
    logic [X_W-1:0]      x0_q, sel_x, scan_x0, scan_x;
    logic [Y_W-1:0]      y0_q, sel_y, scan_y0, scan_y;
    logic [SIZE_W-1:0]   size_q, sel_size, scan_size;
    logic [COL_W-1:0]    colour_q, sel_colour;
    logic                scan_in_bounds, scan_last;

    // Scan upward from the requester after the last grant so nobody starves.
    always_comb begin
        int              tmp;
        logic [ID_W-1:0] idx;
        gnt_onehot = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            tmp = (int'(last_id) + k) % NUM_REQ;
            idx = ID_W'(tmp);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any         = 1'b1;
                gnt_id          = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

    assign idle      = (state == IDLE);
    assign accept    = idle && gnt_any;
    assign req_ready = (idle && resetn) ? gnt_onehot : '0;
    assign busy      = !idle;

    assign sel_x      = req_x[int'(gnt_id)*X_W +: X_W];
    assign sel_y      = req_y[int'(gnt_id)*Y_W +: Y_W];
    assign sel_size   = req_size[int'(gnt_id)*SIZE_W +: SIZE_W];
    assign sel_colour = req_colour[int'(gnt_id)*COL_W +: COL_W];

    // In IDLE the scanner looks at the live request so pixel 0 is ready at the accept edge.
    assign scan_x0   = idle ? sel_x    : x0_q;
    assign scan_y0   = idle ? sel_y    : y0_q;
    assign scan_size = idle ? sel_size : size_q;

    box_scanner #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .SIZE_W (SIZE_W)
    ) u_scanner (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (accept),
        .step      ((state == DRAW) && !scan_last),
        .x0        (scan_x0),
        .y0        (scan_y0),
        .size      (scan_size),
        .x         (scan_x),
        .y         (scan_y),
        .in_bounds (scan_in_bounds),
        .last      (scan_last)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_id    <= ID_W'(NUM_REQ - 1);
            cur_id     <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            size_q     <= '0;
            colour_q   <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        x0_q     <= sel_x;
                        y0_q     <= sel_y;
                        size_q   <= sel_size;
                        colour_q <= sel_colour;
                        cur_id   <= gnt_id;
                        last_id  <= gnt_id;
                        if (sel_size == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            done_id <= gnt_id;
                        end else begin
                            state      <= DRAW;
                            vga_x      <= scan_x;
                            vga_y      <= scan_y;
                            vga_colour <= sel_colour;
                            vga_plot   <= scan_in_bounds;
                        end
                    end
                end
                DRAW: begin
                    if (scan_last) begin
                        state    <= DONE;
                        vga_plot <= 1'b0;
                        done     <= 1'b1;
                        done_id  <= cur_id;
                    end else begin
                        vga_x      <= scan_x;
                        vga_y      <= scan_y;
                        vga_colour <= colour_q;
                        vga_plot   <= scan_in_bounds;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/box_draw_arbiter.md
# box_draw_arbiter

Shared controller for the single `draw_box` pixel datapath and the single VGA adapter. Screen-state modules (start screen, game screens) each raise a box-draw request with origin, size and colour. The block grants one requester at a time by round-robin and sweeps that box pixel by pixel. It drives `x`/`y`/`colour`/`plot` straight into the VGA adapter, replacing the ad-hoc output mux between states.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters.
- `X_W`, 8: x coordinate width (160-pixel screen).
- `Y_W`, 7: y coordinate width (120-line screen).
- `SIZE_W`, 5: box side width (max side 31).
- `COL_W`, 3: colour width.

Ports:
- `CLOCK_50`  in  1: system clock, all state on rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester draw request.
- `req_ready`  out  NUM_REQ: one-hot grant. A request is accepted on an edge where valid&ready.
- `req_x`  in  NUM_REQ*X_W: packed top-left x, slice i belongs to requester i.
- `req_y`  in  NUM_REQ*Y_W: packed top-left y.
- `req_size`  in  NUM_REQ*SIZE_W: packed side length.
- `req_colour`  in  NUM_REQ*COL_W: packed colour.
- `vga_x`  out  X_W: pixel x to VGA adapter.
- `vga_y`  out  Y_W: pixel y.
- `vga_colour`  out  COL_W: pixel colour.
- `vga_plot`  out  1: write-enable to VGA adapter.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a box finishes.
- `done_id`  out  $clog2(NUM_REQ): index of the finished requester, valid while `done`.

## Operation
- FSM states are IDLE, DRAW and DONE.
- IDLE:
  - `req_ready` is combinational: one-hot of the first valid requester scanning from `last+1` mod NUM_REQ upward. It is zero if none are valid.
  - On accept, latch the fields, granted id, column and row counters (0,0), and `last`. Next state is DRAW, or DONE if size==0.
- DRAW:
  - Each cycle emits pixel (x0+col, y0+row). Order is left to right within a row, then rows top to bottom.
  - col wraps at size-1 and increments row. At col==size-1 and row==size-1 the next state is DONE.
- DONE: `done`=1 and `done_id`=granted id for one cycle, then IDLE.
- Requesters hold valid and fields stable until accepted. Fields are sampled only at the accept edge. Later changes do not affect a box in progress.
- `req_ready` is all-zero outside IDLE.
- Arithmetic:
  - x0+col is computed at X_W+1 bits and y0+row at Y_W+1 bits.
  - A pixel with x≥160 or y≥120 is clipped: `vga_plot`=0 but the cycle is still consumed. `vga_x`/`vga_y` show the truncated sum.
- Reset values: state IDLE, `last`=NUM_REQ-1 (so requester 0 wins first), counters 0. All outputs are 0, including `vga_*`, `busy`, `done`, `done_id` and `req_ready`.
- Reset mid-operation: the box is abandoned immediately, no `done` is pulsed, and the requester must re-request.
- A valid requester is never starved. After a grant to i, every other valid requester is served before i again.

## Timing
- Accept edge T.
- Cycles T+1 … T+s² are DRAW: `vga_*` registered, one pixel per cycle.
- Cycle T+s²+1 is DONE.
- Cycle T+s²+2 is IDLE, and a new accept is possible on that cycle's edge.
- Throughput is s²+2 cycles per box. size==0 gives DONE at T+1 and IDLE at T+2.
- `vga_plot` is 0 in IDLE and DONE. `vga_x`/`vga_y`/`vga_colour` hold their last value outside DRAW.

## Structure
- Shared package `vga_pkg`: SCREEN_W=160, SCREEN_H=120, X_W, Y_W, COL_W, and the state enum (IDLE, DRAW, DONE).
- Sub-module `box_scanner`:
  - Holds the col/row counters, the origin add and the clip compare.
  - Inputs: start, x0, y0, size. Outputs: x, y, in_bounds, last.
- The top holds the round-robin arbiter, FSM, latches and output registers.

## Test plan
- Req 0 only, (10,20), size 3, colour 5 → plots (10,20),(11,20),(12,20),(10,21)…(12,22) on cycles T+1…T+9, colour 5 throughout, `done`/`done_id`=0 at T+10.
- Reqs 1 and 2 valid together, size 2 each, after reset → 1 granted first. 2 granted in the IDLE cycle after 1's DONE (T+6). 1 re-raised afterwards waits until 2 completes.
- Req 3, size 0 → `done` at T+1, no `vga_plot` cycles, `req_ready` back in IDLE at T+2.
- Req 0, (158,118), size 4 → 16 DRAW cycles, `vga_plot` high only for (158,118),(159,118),(158,119),(159,119).
- `resetn` low at T+4 of a size-5 box → all outputs 0 immediately, no `done`. After release the same valid request is re-granted and all 25 pixels are drawn.
- Requester changes `req_x` after accept → drawn box uses the originally sampled x.
